// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared types and helpers for the execute/write-back stage:
//             datapath widths, opcode and state enumerations, and opcode
//             property helpers.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int DW = 8;   // RF word width
    localparam int AW = 3;   // RF address width

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MOV = 4'd7,
        OP_MUL = 4'd8,
        OP_CMP = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        WB   = 2'd3
    } ex_state_e;

    // Opcodes that produce an RF write (subject to rd != 0).
    function automatic logic op_writes(op_e op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_MOV, OP_MUL: op_writes = 1'b1;
            default:                        op_writes = 1'b0;
        endcase
    endfunction

    // Opcodes that update Z/C; the undefined codes 10-15 act as NOPs.
    function automatic logic op_sets_flags(op_e op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_MOV, OP_MUL, OP_CMP: op_sets_flags = 1'b1;
            default:                                op_sets_flags = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mul_seq
//  Purpose  : Unsigned shift-add multiplier, one partial product per cycle,
//             exactly DW cycles per multiply.
//  Ports    : clk, rst (async, active-low)
//             i_start      load operands and begin (ignored result of any
//                          multiply in progress)
//             i_a, i_b     multiplicand / multiplier
//             o_busy       multiply in progress
//             o_done       high in the final step cycle
//             o_product    2*DW-bit product, valid while o_done is high
//  Revision : 1.0  initial release
// ============================================================================
module mul_seq #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [2*DW-1:0] o_product
);

    localparam int CW = $clog2(DW + 1);

    logic [2*DW-1:0] r_acc;
    logic [2*DW-1:0] r_mcand;
    logic [DW-1:0]   r_mplier;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic [2*DW-1:0] w_acc_next;

    // Accumulator value after the current step; exposed as the product so the
    // consumer can capture the final result on the same edge as the last step.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{DW{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= CW'(DW);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[2*DW-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[DW-1:1]};
            r_cnt    <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == CW'(1));
    assign o_product = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/exec_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module   : exec_wb_unit
//  Purpose  : Execute/write-back stage behind the 8-entry RF. Accepts one
//             instruction per valid/ready handshake, reads operands, runs an
//             ALU op (1 cycle) or a DW-cycle multiply, then writes back and
//             updates the Z/C flags.
//  Ports    : clk, rst (async, active-low)
//             i_valid/o_ready/o_busy        instruction handshake
//             i_op,i_rd,i_rs0,i_rs1,i_imm,i_use_imm   decoded fields
//             o_r_addr_0/1, i_r_data_0/1    RF read ports (combinational)
//             o_rf_w_en, o_w_addr, o_w_data RF write port
//             o_flag_z, o_flag_c            status flags
//  Revision : 1.0  initial release
// ============================================================================
module exec_wb_unit
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [3:0]    i_op,
    input  logic [AW-1:0] i_rd,
    input  logic [AW-1:0] i_rs0,
    input  logic [AW-1:0] i_rs1,
    input  logic [DW-1:0] i_imm,
    input  logic          i_use_imm,
    output logic [AW-1:0] o_r_addr_0,
    output logic [AW-1:0] o_r_addr_1,
    input  logic [DW-1:0] i_r_data_0,
    input  logic [DW-1:0] i_r_data_1,
    output logic          o_rf_w_en,
    output logic [AW-1:0] o_w_addr,
    output logic [DW-1:0] o_w_data,
    output logic          o_flag_z,
    output logic          o_flag_c,
    output logic          o_busy
);

    ex_state_e       r_state;
    ex_state_e       w_next_state;
    logic            w_ready;
    logic            w_mul_start;

    op_e             r_op;
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_rs0;
    logic [AW-1:0]   r_rs1;
    logic [DW-1:0]   r_imm;
    logic            r_use_imm;

    logic            r_rf_w_en;
    logic [AW-1:0]   r_w_addr;
    logic [DW-1:0]   r_w_data;
    logic            r_pend_z;
    logic            r_pend_c;
    logic            r_flag_z;
    logic            r_flag_c;

    logic [DW-1:0]   w_a;
    logic [DW-1:0]   w_b;
    logic [DW:0]     w_sum;
    logic [DW:0]     w_diff;
    logic [DW-1:0]   w_alu_res;
    logic            w_alu_c;

    logic            w_mul_busy;
    logic            w_mul_done;
    logic [2*DW-1:0] w_mul_prod;

    logic            w_accept;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_mul_start  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (i_valid) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                if (r_op == OP_MUL) begin
                    w_mul_start  = 1'b1;
                    w_next_state = MUL;
                end else begin
                    w_next_state = WB;
                end
            end
            MUL: begin
                // An idle multiplier here can only follow a glitch; leave
                // rather than wait forever.
                if (w_mul_done || !w_mul_busy) begin
                    w_next_state = WB;
                end
            end
            WB: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_accept = w_ready && i_valid;

    // ------------------------------------------------------------------
    // Operand fetch and ALU
    // ------------------------------------------------------------------
    assign o_r_addr_0 = r_rs0;
    assign o_r_addr_1 = r_rs1;

    assign w_a    = i_r_data_0;
    assign w_b    = r_use_imm ? r_imm : i_r_data_1;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    // Top bit of the extended difference is the borrow (A < B).
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        case (r_op)
            OP_ADD: {w_alu_c, w_alu_res} = w_sum;
            OP_SUB,
            OP_CMP: {w_alu_c, w_alu_res} = w_diff;
            OP_AND: w_alu_res = w_a & w_b;
            OP_OR:  w_alu_res = w_a | w_b;
            OP_XOR: w_alu_res = w_a ^ w_b;
            OP_SHL: begin
                w_alu_res = {w_a[DW-2:0], 1'b0};
                w_alu_c   = w_a[DW-1];
            end
            OP_SHR: begin
                w_alu_res = {1'b0, w_a[DW-1:1]};
                w_alu_c   = w_a[0];
            end
            OP_MOV: w_alu_res = w_b;
            default: begin
                w_alu_res = '0;
                w_alu_c   = 1'b0;
            end
        endcase
    end

    mul_seq #(
        .DW (DW)
    ) u_mul_seq (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    // ------------------------------------------------------------------
    // Captured fields, write-back registers and flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= OP_ADD;
            r_rd      <= '0;
            r_rs0     <= '0;
            r_rs1     <= '0;
            r_imm     <= '0;
            r_use_imm <= 1'b0;
            r_rf_w_en <= 1'b0;
            r_w_addr  <= '0;
            r_w_data  <= '0;
            r_pend_z  <= 1'b0;
            r_pend_c  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= op_e'(i_op);
                r_rd      <= i_rd;
                r_rs0     <= i_rs0;
                r_rs1     <= i_rs1;
                r_imm     <= i_imm;
                r_use_imm <= i_use_imm;
            end

            // Write enable is loaded on the edge entering WB, so it is high
            // for the WB cycle only; address/data hold until the next WB.
            r_rf_w_en <= 1'b0;

            if ((r_state == EXEC) && (r_op != OP_MUL)) begin
                r_w_addr  <= r_rd;
                r_w_data  <= w_alu_res;
                r_rf_w_en <= op_writes(r_op) && (r_rd != '0);
                r_pend_z  <= (w_alu_res == '0);
                r_pend_c  <= w_alu_c;
            end

            if ((r_state == MUL) && w_mul_done) begin
                r_w_addr  <= r_rd;
                r_w_data  <= w_mul_prod[DW-1:0];
                r_rf_w_en <= (r_rd != '0);
                r_pend_z  <= (w_mul_prod[DW-1:0] == '0);
                r_pend_c  <= |w_mul_prod[2*DW-1:DW];
            end

            if ((r_state == WB) && op_sets_flags(r_op)) begin
                r_flag_z <= r_pend_z;
                r_flag_c <= r_pend_c;
            end
        end
    end

    assign o_ready   = w_ready;
    assign o_busy    = ~w_ready;
    assign o_rf_w_en = r_rf_w_en;
    assign o_w_addr  = r_w_addr;
    assign o_w_data  = r_w_data;
    assign o_flag_z  = r_flag_z;
    assign o_flag_c  = r_flag_c;

endmodule
`default_nettype wire

// File: tb/tb_exec_wb_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_wb_unit
//  Purpose  : Self-checking bench for exec_wb_unit: directed vector table,
//             reset and handshake sequences, and a random instruction stream
//             checked against an architectural RF + flags model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exec_wb_unit;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_op;
    logic [2:0] i_rd, i_rs0, i_rs1;
    logic [7:0] i_imm;
    logic       i_use_imm;
    logic [2:0] o_r_addr_0, o_r_addr_1;
    logic [7:0] i_r_data_0, i_r_data_1;
    logic       o_rf_w_en;
    logic [2:0] o_w_addr;
    logic [7:0] o_w_data;
    logic       o_flag_z, o_flag_c, o_busy;

    int n_tests = 0;
    int n_fail  = 0;

    exec_wb_unit #(.DW(8), .AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_rd       (i_rd),
        .i_rs0      (i_rs0),
        .i_rs1      (i_rs1),
        .i_imm      (i_imm),
        .i_use_imm  (i_use_imm),
        .o_r_addr_0 (o_r_addr_0),
        .o_r_addr_1 (o_r_addr_1),
        .i_r_data_0 (i_r_data_0),
        .i_r_data_1 (i_r_data_1),
        .o_rf_w_en  (o_rf_w_en),
        .o_w_addr   (o_w_addr),
        .o_w_data   (o_w_data),
        .o_flag_z   (o_flag_z),
        .o_flag_c   (o_flag_c),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file the DUT talks to (r0 never written, so reads 0).
    logic [7:0] rf [8];
    assign i_r_data_0 = rf[o_r_addr_0];
    assign i_r_data_1 = rf[o_r_addr_1];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (o_rf_w_en && (o_w_addr != 3'd0)) begin
            rf[o_w_addr] <= o_w_data;
        end
    end

    // Architectural reference state.
    int ref_rf [8];
    bit ref_z, ref_c;

    task automatic ref_reset();
        for (int i = 0; i < 8; i++) ref_rf[i] = 0;
        ref_z = 1'b0;
        ref_c = 1'b0;
    endtask

    // Predict one instruction: cycle of the write pulse (-1 = none), data.
    task automatic ref_exec(input logic [3:0] op, input logic [2:0] rd,
                            input logic [2:0] rs0, input logic [2:0] rs1,
                            input logic [7:0] imm, input logic use_imm,
                            output int cyc, output logic [7:0] data);
        int a, b, r;
        bit c, wr, fl;
        a  = ref_rf[rs0];
        b  = use_imm ? int'(imm) : ref_rf[rs1];
        r  = 0; c = 1'b0; wr = 1'b1; fl = 1'b1;
        case (op)
            4'd0: begin r = a + b; c = (r > 255); end
            4'd1: begin r = a - b; c = (a < b);   end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin r = a * 2; c = (a >= 128); end
            4'd6: begin r = a / 2; c = (a % 2 == 1); end
            4'd7: r = b;
            4'd8: begin r = a * b; c = (r > 255); end
            4'd9: begin r = a - b; c = (a < b); wr = 1'b0; end
            default: begin wr = 1'b0; fl = 1'b0; end
        endcase
        r    = r & 255;
        data = 8'(r);
        cyc  = (wr && rd != 3'd0) ? ((op == 4'd8) ? 10 : 2) : -1;
        if (cyc > 0) ref_rf[rd] = r;
        if (fl) begin
            ref_z = (r == 0);
            ref_c = c;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Issue one instruction from a negedge and follow it until the DUT is
    // idle again. Returns the cycle (1 = cycle after accept) of the write
    // pulse, -1 if none, 99 if more than one.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs0, input logic [2:0] rs1,
                         input logic [7:0] imm, input logic use_imm,
                         output int cyc, output logic [7:0] data,
                         output logic [2:0] addr);
        int  k;
        bit  done;
        cyc = -1; data = 8'h00; addr = 3'd0;
        k = 0;
        while (!o_ready && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (!o_ready) begin
            timeout_fail("issue_ready");
            return;
        end
        i_valid = 1'b1; i_op = op; i_rd = rd; i_rs0 = rs0; i_rs1 = rs1;
        i_imm = imm; i_use_imm = use_imm;
        @(negedge clk);
        i_valid = 1'b0;
        done = 1'b0;
        for (int j = 1; j <= 20 && !done; j++) begin
            if (o_rf_w_en) begin
                cyc  = (cyc < 0) ? j : 99;
                data = o_w_data;
                addr = o_w_addr;
            end
            if (o_ready) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) timeout_fail("issue_done");
    endtask

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd, rs0, rs1;
        logic [7:0] imm;
        logic       use_imm;
        int         exp_cyc;
        logic [7:0] exp_data;
        logic       exp_z, exp_c;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc, e1, e2, w1, w2, acc, wen_seen;
        logic [7:0] data, d1, d2, wd1, wd2, rimm;
        logic [2:0] addr, rrd, rs0, rs1;
        logic [3:0] rop;
        logic       rui;
        vec_t       v;

        //              op    rd    rs0   rs1   imm    ui    cyc data   z     c
        vecs.push_back('{4'd7, 3'd1, 3'd0, 3'd0, 8'hF0, 1'b1, 2,  8'hF0, 1'b0, 1'b0});
        vecs.push_back('{4'd0, 3'd2, 3'd1, 3'd0, 8'h20, 1'b1, 2,  8'h10, 1'b0, 1'b1});
        vecs.push_back('{4'd1, 3'd3, 3'd1, 3'd1, 8'h00, 1'b0, 2,  8'h00, 1'b1, 1'b0});
        vecs.push_back('{4'd1, 3'd4, 3'd0, 3'd0, 8'h01, 1'b1, 2,  8'hFF, 1'b0, 1'b1});
        vecs.push_back('{4'd7, 3'd5, 3'd0, 3'd0, 8'h0F, 1'b1, 2,  8'h0F, 1'b0, 1'b0});
        vecs.push_back('{4'd8, 3'd7, 3'd5, 3'd0, 8'h11, 1'b1, 10, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{4'd7, 3'd6, 3'd0, 3'd0, 8'h10, 1'b1, 2,  8'h10, 1'b0, 1'b0});
        vecs.push_back('{4'd8, 3'd6, 3'd6, 3'd6, 8'h00, 1'b0, 10, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{4'd0, 3'd0, 3'd0, 3'd0, 8'h05, 1'b1, -1, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{4'd7, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 2,  8'h05, 1'b0, 1'b0});
        vecs.push_back('{4'd9, 3'd3, 3'd1, 3'd0, 8'h05, 1'b1, -1, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{4'd12,3'd2, 3'd1, 3'd0, 8'h33, 1'b1, -1, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{4'd7, 3'd2, 3'd0, 3'd0, 8'h81, 1'b1, 2,  8'h81, 1'b0, 1'b0});
        vecs.push_back('{4'd5, 3'd3, 3'd2, 3'd0, 8'h00, 1'b0, 2,  8'h02, 1'b0, 1'b1});
        vecs.push_back('{4'd6, 3'd3, 3'd2, 3'd0, 8'h00, 1'b0, 2,  8'h40, 1'b0, 1'b1});
        vecs.push_back('{4'd2, 3'd4, 3'd2, 3'd0, 8'h0F, 1'b1, 2,  8'h01, 1'b0, 1'b0});
        vecs.push_back('{4'd3, 3'd4, 3'd2, 3'd0, 8'h0F, 1'b1, 2,  8'h8F, 1'b0, 1'b0});
        vecs.push_back('{4'd4, 3'd4, 3'd2, 3'd0, 8'h81, 1'b1, 2,  8'h00, 1'b1, 1'b0});
        vecs.push_back('{4'd1, 3'd5, 3'd1, 3'd2, 8'h00, 1'b0, 2,  8'h84, 1'b0, 1'b1});
        vecs.push_back('{4'd0, 3'd6, 3'd2, 3'd2, 8'h00, 1'b0, 2,  8'h02, 1'b0, 1'b1});

        rst = 1'b0; i_valid = 1'b0; i_op = 4'd0; i_rd = 3'd0; i_rs0 = 3'd0;
        i_rs1 = 3'd0; i_imm = 8'h00; i_use_imm = 1'b0;
        ref_reset();

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_ready",  int'(o_ready),   1);
        check("rst_busy",   int'(o_busy),    0);
        check("rst_wen",    int'(o_rf_w_en), 0);
        check("rst_flags",  int'({o_flag_z, o_flag_c}), 0);
        check("rst_waddr",  int'(o_w_addr),  0);
        check("rst_wdata",  int'(o_w_data),  0);
        check("rst_raddr",  int'({o_r_addr_0, o_r_addr_1}), 0);
        rst = 1'b1;
        @(negedge clk);

        // ---- reset in the 4th MUL cycle aborts the write ----
        i_valid = 1'b1; i_op = 4'd8; i_rd = 3'd7; i_rs0 = 3'd0; i_rs1 = 3'd0;
        i_imm = 8'h03; i_use_imm = 1'b1;
        @(negedge clk);             // cycle 1 (EXEC)
        i_valid = 1'b0;
        wen_seen = 0;
        repeat (4) begin            // cycles 2..5 = MUL 1..4
            @(negedge clk);
            if (o_rf_w_en) wen_seen++;
        end
        #2 rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (o_rf_w_en) wen_seen++;
        end
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (o_rf_w_en) wen_seen++;
        end
        check("mulrst_no_write", wen_seen, 0);
        check("mulrst_ready", int'(o_ready), 1);
        check("mulrst_flags", int'({o_flag_z, o_flag_c}), 0);
        ref_reset();

        // ---- directed vector table ----
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            ref_exec(v.op, v.rd, v.rs0, v.rs1, v.imm, v.use_imm, e1, d1);
            issue(v.op, v.rd, v.rs0, v.rs1, v.imm, v.use_imm, cyc, data, addr);
            check($sformatf("vec%0d_wen_cycle", i), cyc, v.exp_cyc);
            if (v.exp_cyc > 0) begin
                check($sformatf("vec%0d_wdata", i), int'(data), int'(v.exp_data));
                check($sformatf("vec%0d_waddr", i), int'(addr), int'(v.rd));
                check($sformatf("vec%0d_rf", i), int'(rf[v.rd]), int'(v.exp_data));
            end
            check($sformatf("vec%0d_z", i), int'(o_flag_z), int'(v.exp_z));
            check($sformatf("vec%0d_c", i), int'(o_flag_c), int'(v.exp_c));
        end

        // ---- i_valid held through a MUL; dependent ADD reads its result ----
        ref_exec(4'd8, 3'd7, 3'd5, 3'd0, 8'h03, 1'b1, e1, d1);
        ref_exec(4'd0, 3'd1, 3'd7, 3'd0, 8'h01, 1'b1, e2, d2);
        i_valid = 1'b1; i_op = 4'd8; i_rd = 3'd7; i_rs0 = 3'd5; i_rs1 = 3'd0;
        i_imm = 8'h03; i_use_imm = 1'b1;
        @(negedge clk);
        i_op = 4'd0; i_rd = 3'd1; i_rs0 = 3'd7; i_imm = 8'h01;
        w1 = -1; w2 = -1; acc = -1; wd1 = 8'h00; wd2 = 8'h00;
        for (int j = 1; j <= 20; j++) begin
            if (o_rf_w_en) begin
                if (w1 < 0)      begin w1 = j; wd1 = o_w_data; end
                else if (w2 < 0) begin w2 = j; wd2 = o_w_data; end
            end
            if (o_ready && acc < 0) acc = j;
            @(negedge clk);
            if (acc > 0) i_valid = 1'b0;
        end
        check("hs_first_idle", acc, 11);
        check("hs_mul_wen_cycle", w1, e1);
        check("hs_mul_data", int'(wd1), int'(d1));
        check("hs_add_wen_cycle", w2, 13);
        check("hs_add_data", int'(wd2), int'(d2));
        check("hs_z", int'(o_flag_z), int'(ref_z));
        check("hs_c", int'(o_flag_c), int'(ref_c));

        // ---- random stream ----
        for (int i = 0; i < 500; i++) begin
            rop  = 4'($urandom_range(0, 15));
            rrd  = 3'($urandom_range(0, 7));
            rs0  = 3'($urandom_range(0, 7));
            rs1  = 3'($urandom_range(0, 7));
            rimm = 8'($urandom_range(0, 255));
            rui  = 1'($urandom_range(0, 1));
            ref_exec(rop, rrd, rs0, rs1, rimm, rui, e1, d1);
            issue(rop, rrd, rs0, rs1, rimm, rui, cyc, data, addr);
            check($sformatf("rnd%0d_op%0d_wen_cycle", i, rop), cyc, e1);
            if (e1 > 0) begin
                check($sformatf("rnd%0d_op%0d_wdata", i, rop), int'(data), int'(d1));
                check($sformatf("rnd%0d_op%0d_waddr", i, rop), int'(addr), int'(rrd));
            end
            check($sformatf("rnd%0d_op%0d_z", i, rop), int'(o_flag_z), int'(ref_z));
            check($sformatf("rnd%0d_op%0d_c", i, rop), int'(o_flag_c), int'(ref_c));
        end
        for (int r = 1; r < 8; r++) begin
            check($sformatf("final_rf%0d", r), int'(rf[r]), ref_rf[r]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exec_wb_unit.md
Name: exec_wb_unit

Overview:
- Execute/write-back stage sitting directly downstream of the 8-entry RF.
- Accepts one decoded instruction at a time through a valid/ready handshake.
- Reads the RF, executes one ALU op or an 8-cycle shift-add multiply, then drives the RF write port and updates Z/C flags.
- Processes one instruction at a time, so no bypass or forwarding is needed.

Parameters:
- DW, 8, datapath width (RF word width).
- AW, 3, RF address width (2**AW registers; r0 hardwired to zero inside RF).

Ports:
- clk, in, 1, single clock, all state on rising edge.
- rst, in, 1, asynchronous active-low reset (asserted when 0).
- i_valid, in, 1, instruction fields valid.
- o_ready, out, 1, unit can accept an instruction this cycle.
- i_op, in, 4, opcode (op_e).
- i_rd, in, AW, destination register.
- i_rs0, in, AW, operand A source register.
- i_rs1, in, AW, operand B source register.
- i_imm, in, DW, immediate.
- i_use_imm, in, 1, operand B = i_imm instead of RF.
- o_r_addr_0, out, AW, to RF r_addr_0.
- o_r_addr_1, out, AW, to RF r_addr_1.
- i_r_data_0, in, DW, from RF o_r_data_0 (combinational read).
- i_r_data_1, in, DW, from RF o_r_data_1.
- o_rf_w_en, out, 1, to RF RF_w_en.
- o_w_addr, out, AW, to RF w_addr.
- o_w_data, out, DW, to RF w_data.
- o_flag_z, out, 1, zero flag.
- o_flag_c, out, 1, carry/borrow flag.
- o_busy, out, 1, instruction in flight (= ~o_ready).

Behaviour:
- Reset (rst=0, async): state IDLE; o_ready=1; o_rf_w_en=0; o_w_addr=0; o_w_data=0; o_r_addr_0/1=0; flags=0; all captured fields cleared. Reset mid-MUL or mid-WB aborts; no RF write occurs.
- States: IDLE -> EXEC -> (MUL x DW cycles) -> WB -> IDLE.
- IDLE: o_ready=1. Accept on i_valid&&o_ready at a clock edge; capture op, rd, rs0, rs1, imm, use_imm; go to EXEC. i_valid while busy is ignored; upstream holds it until accepted.
- EXEC (1 cycle): o_r_addr_0=rs0, o_r_addr_1=rs1. A=i_r_data_0; B=use_imm?imm:i_r_data_1.
  - Non-MUL: result and carry registered, go to WB.
  - MUL: load A/B into the multiplier, go to MUL.
- MUL: one shift-add step per cycle, exactly DW cycles, then WB.
- WB (1 cycle): o_w_addr=rd, o_w_data=result, o_rf_w_en=1 only if op writes and rd!=0. Flags update at the end of WB for every legal op, including rd=0. Next state IDLE.
- Latency, accept edge to o_rf_w_en high: ALU ops = 2nd cycle after accept; MUL = 10th cycle (1 EXEC + 8 MUL + WB).
- Back-to-back dependent ops are safe: the next EXEC follows the RF write edge.
- Ops, DW-bit wrap:
  - 0 ADD: C = carry out.
  - 1 SUB A-B: C = borrow (A<B).
  - 2 AND, 3 OR, 4 XOR: C = 0.
  - 5 SHL A by 1: C = A[7].
  - 6 SHR A by 1: C = A[0].
  - 7 MOV = B: C = 0.
  - 8 MUL: result = low DW of A*B; C = |high DW.
  - 9 CMP: A-B flags only, no write.
  - 10-15: NOP; pass through all states, no write, flags unchanged.
- Z = (result==0), for CMP computed on the difference.
- o_rf_w_en is high only in WB. Outside WB, o_w_addr and o_w_data hold their last values.

Decomposition:
- cpu_pkg holds: DW/AW localparams; op_e enum (4-bit); ex_state_e enum {IDLE, EXEC, MUL, WB}; function op_writes(op_e).
- One sub-module: mul_seq (start, a, b -> busy, done, 2*DW product; shift-add, DW cycles).

Test Plan:
- Reset: hold rst=0 for 2 cycles -> o_ready=1, o_rf_w_en=0, flags 00. Issue MUL, drop rst at MUL cycle 4 -> no write ever; o_ready=1 after release.
- MOV r1,#0xF0 then ADD r2=r1+#0x20 -> w_en in 2nd cycle after accept, w_addr=2, w_data=0x10, C=1, Z=0; RF r2 reads 0x10.
- SUB r3=r1-r1 -> 0x00, Z=1, C=0. SUB r4=r0-#0x01 -> 0xFF, C=1, Z=0.
- MUL 0x0F*0x11 -> 0xFF, C=0, w_en exactly 10 cycles after accept. MUL 0x10*0x10 -> 0x00, Z=1, C=1.
- ADD rd=0 with result 0x05 -> o_rf_w_en stays 0, Z=0. CMP 0x05 vs 0x05 -> no write, Z=1. Opcode 12 -> no write, flags unchanged.
- Handshake: i_valid held high during MUL -> second instruction accepted only in the first IDLE cycle. Dependent ADD reads the MUL result. Random 500-op stream checked against a reference RF+flags model.
